axi_vga_fetch_sched: RTL and testbench
======================================

# axi_vga_fetch_sched

Read-request scheduler for the VGA framebuffer fetch path, clocked in the bus (`clk_i`) domain. Once per frame it walks the framebuffer from a programmed base address and issues fixed-length AXI read bursts. It issues a burst only when the pixel async FIFO is guaranteed to have room for every beat of it, using credits. It sits between the register file and the AXI AR channel; the returning R beats are pushed into the async FIFO write port.

## Interface

Parameters:
- `AXIDataWidth`, default 64: data beat width in bits; sets the address stride.
- `AddrWidth`, default 64: AXI address width.
- `FifoDepth`, default 64: entries in the downstream async FIFO; must equal 2^LGFIFO of that FIFO.
- `BurstLen`, default 16: beats per burst; power of two, 1..256, ≤ FifoDepth.

Ports:
- `clk_i`, in, 1: bus clock. This is the only clock.
- `rst_ni`, in, 1: reset, synchronous and active-low.
- `enable_i`, in, 1: level. Scanout is enabled while high.
- `fb_base_i`, in, AddrWidth: framebuffer base address. Must be aligned to BurstLen*AXIDataWidth/8 bytes.
- `frame_beats_i`, in, 32: beats per frame. Must be a nonzero multiple of BurstLen.
- `frame_start_i`, in, 1: single-cycle pulse, already synchronized into `clk_i`.
- `fifo_level_i`, in, $clog2(FifoDepth)+1: FIFO fill level as seen in the write domain. It may over-report but never under-report.
- `beat_push_i`, in, 1: one R beat was written into the FIFO this cycle.
- `ar_valid_o`, out, 1: AR request valid.
- `ar_ready_i`, in, 1: AR request accepted.
- `ar_addr_o`, out, AddrWidth: burst start address.
- `ar_len_o`, out, 8: constant value BurstLen-1.
- `busy_o`, out, 1: high whenever the state is not IDLE or WAIT_FRAME.
- `overrun_o`, out, 1: sticky flag. Set when `frame_start_i` arrives while a frame is still being fetched.

## Operation

States: IDLE, WAIT_FRAME, ISSUE, DRAIN.

- IDLE
  - Goes to WAIT_FRAME when `enable_i`=1.
  - `overrun_o` clears while in IDLE.
- WAIT_FRAME
  - On `frame_start_i`: go to ISSUE, load addr=`fb_base_i`, load remaining=`frame_beats_i`.
  - If `enable_i`=0: go to IDLE.
- ISSUE
  - Raises `ar_valid_o` when `fifo_level_i` + outstanding + BurstLen ≤ FifoDepth.
  - On each AR handshake:
    - addr += BurstLen*AXIDataWidth/8, wrapping modulo 2^AddrWidth;
    - remaining −= BurstLen;
    - outstanding += BurstLen.
  - When remaining reaches 0 after a handshake: go to DRAIN.
  - If `enable_i`=0 with `ar_valid_o` low: go to DRAIN.
  - If `enable_i`=0 with `ar_valid_o` high: hold the request until handshake, then go to DRAIN.
- DRAIN
  - Issues no requests.
  - Stays until outstanding == 0.
  - Then:
    - if `enable_i`=0: go to IDLE;
    - else if restart pending: go to ISSUE with reloaded addr and remaining, and clear pending;
    - else: go to WAIT_FRAME.
- Outstanding counter
  - Width: $clog2(FifoDepth)+1 bits.
  - Decrements on `beat_push_i`.
  - Handshake and push in the same cycle: net change is +BurstLen−1.
  - A `beat_push_i` while outstanding is 0 is ignored; the counter saturates at 0.
- `frame_start_i` in ISSUE or DRAIN:
  - sets `overrun_o`;
  - sets restart pending.
  - It never aborts bursts already in flight.
- AXI rule: once `ar_valid_o` is high, it and `ar_addr_o` stay stable until `ar_ready_i`.
- Input sampling: `fb_base_i` and `frame_beats_i` are sampled only at the transition into ISSUE.

## Timing

- Reset values:
  - state IDLE;
  - `ar_valid_o`=0, `ar_addr_o`=0;
  - `busy_o`=0, `overrun_o`=0;
  - outstanding=0, remaining=0, pending=0.
- `ar_len_o` is constant BurstLen-1, including during reset.
- All outputs are registered.
- Frame start:
  - `frame_start_i` seen in cycle N (in WAIT_FRAME);
  - `ar_valid_o` high in cycle N+1 with `ar_addr_o`=`fb_base_i`, provided the credit condition passes.
- Back-to-back requests: after a handshake in cycle N, the next `ar_valid_o` may be high in cycle N+1. The credit check in that cycle uses the already-updated outstanding count.
- DRAIN exit: outstanding reaches 0 in cycle N; the next state takes effect in cycle N+1.
- Reset mid-frame:
  - all state returns to reset values on the next edge;
  - in-flight beats are not tracked after reset.

## Test plan

- Normal frame (FifoDepth=64, BurstLen=16, fb_base=0x8000_0000, frame_beats=64, level=0, ar_ready tied 1, each burst's 16 pushes start 2 cycles after its AR):
  - exactly 4 ARs at 0x8000_0000, 0x8000_0080, 0x8000_0100, 0x8000_0180, each with len=15;
  - DRAIN, then WAIT_FRAME once the 64 pushes are seen.
- Credit stall: level=40, no pushes:
  - one AR issues (40+0+16 ≤ 64);
  - the second is blocked (40+16+16 > 64);
  - lowering level to 32 releases it the next cycle.
- AR backpressure: `ar_ready_i`=0 for 10 cycles → `ar_valid_o` and addr stay constant; the handshake occurs on the first ready cycle.
- Simultaneous AR handshake and push with outstanding=5 → outstanding=20.
- Overrun: `frame_start_i` during ISSUE →
  - `overrun_o`=1;
  - after drain, ISSUE restarts at `fb_base_i` without waiting for another pulse;
  - deasserting enable clears `overrun_o` in IDLE.
- `rst_ni`=0 for one edge during ISSUE with `ar_valid_o`=1 → next cycle all outputs are at their reset values and the state is IDLE.

Source files
------------

// File: rtl/axi_vga_fetch_sched.sv
// Frame-by-frame AXI AR burst scheduler for the VGA framebuffer fetch path.
// Bursts are issued only when the downstream pixel FIFO has guaranteed room for every beat.
module axi_vga_fetch_sched #(
    parameter int unsigned AXIDataWidth = 64,
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned FifoDepth    = 64,
    parameter int unsigned BurstLen     = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic [AddrWidth-1:0]         fb_base_i,
    input  logic [31:0]                  frame_beats_i,
    input  logic                         frame_start_i,
    input  logic [$clog2(FifoDepth):0]   fifo_level_i,
    input  logic                         beat_push_i,
    output logic                         ar_valid_o,
    input  logic                         ar_ready_i,
    output logic [AddrWidth-1:0]         ar_addr_o,
    output logic [7:0]                   ar_len_o,
    output logic                         busy_o,
    output logic                         overrun_o
);

    localparam int unsigned CW = $clog2(FifoDepth) + 1;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_FRAME = 2'd1;
    localparam logic [1:0] ISSUE      = 2'd2;
    localparam logic [1:0] DRAIN      = 2'd3;

    localparam logic [AddrWidth-1:0] STRIDE      = AddrWidth'(BurstLen * (AXIDataWidth / 8));
    localparam logic [CW-1:0]        BURST_CR    = CW'(BurstLen);
    localparam logic [31:0]          BURST_BEATS = 32'(BurstLen);
    localparam logic [CW+1:0]        DEPTH_W     = (CW + 2)'(FifoDepth);

    logic [1:0]           state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [31:0]          rem_q, rem_d;
    logic [CW-1:0]        out_q, out_d;
    logic                 pend_q, pend_d;
    logic                 overrun_q, overrun_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 hs;
    logic [CW+1:0]        credit_need;

    assign hs          = valid_q & ar_ready_i;
    assign ar_valid_o  = valid_q;
    assign ar_addr_o   = addr_q;
    assign ar_len_o    = 8'(BurstLen - 1);
    assign busy_o      = busy_q;
    assign overrun_o   = overrun_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        pend_d    = pend_q;
        overrun_d = overrun_q;

        out_d = out_q;
        if (hs) out_d = out_d + BURST_CR;
        if (beat_push_i && (out_q != '0)) out_d = out_d - CW'(1);

        case (state_q)
            IDLE: begin
                overrun_d = 1'b0;
                pend_d    = 1'b0;
                if (enable_i) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (frame_start_i) begin
                    state_d = ISSUE;
                    addr_d  = fb_base_i;
                    rem_d   = frame_beats_i;
                end
            end
            ISSUE: begin
                if (frame_start_i) begin
                    overrun_d = 1'b1;
                    pend_d    = 1'b1;
                end
                if (hs) begin
                    addr_d = addr_q + STRIDE;
                    rem_d  = rem_q - BURST_BEATS;
                    if ((rem_d == '0) || !enable_i) state_d = DRAIN;
                end else if (!valid_q && (!enable_i || (rem_q == '0))) begin
                    state_d = DRAIN;
                end
            end
            default: begin
                if (frame_start_i) begin
                    overrun_d = 1'b1;
                    pend_d    = 1'b1;
                end
                if (out_q == '0) begin
                    if (!enable_i) begin
                        state_d = IDLE;
                        pend_d  = 1'b0;
                    end else if (pend_q || frame_start_i) begin
                        state_d = ISSUE;
                        addr_d  = fb_base_i;
                        rem_d   = frame_beats_i;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = WAIT_FRAME;
                    end
                end
            end
        endcase

        // Credit check uses the post-update outstanding count so back-to-back bursts stay safe.
        credit_need = (CW + 2)'(fifo_level_i) + (CW + 2)'(out_d) + (CW + 2)'(BurstLen);
        if (valid_q && !ar_ready_i) begin
            valid_d = 1'b1;
        end else begin
            valid_d = (state_d == ISSUE) && (rem_d != '0) && enable_i && (credit_need <= DEPTH_W);
        end
        busy_d = (state_d == ISSUE) || (state_d == DRAIN);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            out_q     <= '0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            out_q     <= out_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_axi_vga_fetch_sched.sv
// Scoreboard bench for axi_vga_fetch_sched: expected AR addresses are queued when a frame
// is started and popped as each AR handshake is observed.
module tb_axi_vga_fetch_sched;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 64;
    localparam int unsigned FD = 64;
    localparam int unsigned BL = 16;
    localparam int unsigned LW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [AW-1:0] fb_base;
    logic [31:0]   frame_beats;
    logic          frame_start;
    logic [LW-1:0] fifo_level;
    logic          beat_push;
    logic          ar_valid;
    logic          ar_ready;
    logic [AW-1:0] ar_addr;
    logic [7:0]    ar_len;
    logic          busy;
    logic          overrun;

    always #5 clk = ~clk;

    axi_vga_fetch_sched #(
        .AXIDataWidth(DW),
        .AddrWidth   (AW),
        .FifoDepth   (FD),
        .BurstLen    (BL)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .fb_base_i    (fb_base),
        .frame_beats_i(frame_beats),
        .frame_start_i(frame_start),
        .fifo_level_i (fifo_level),
        .beat_push_i  (beat_push),
        .ar_valid_o   (ar_valid),
        .ar_ready_i   (ar_ready),
        .ar_addr_o    (ar_addr),
        .ar_len_o     (ar_len),
        .busy_o       (busy),
        .overrun_o    (overrun)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          hs_total = 0;
    int          pushes = 0;
    int          owed = 0;
    bit          auto_push = 1'b0;
    logic [63:0] sb[$];
    int          push_starts[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the edge. Auto mode returns
    // each burst's beats starting two cycles after its AR handshake.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (auto_push) begin
            while (push_starts.size() > 0 && push_starts[0] + 2 <= cyc) begin
                void'(push_starts.pop_front());
                owed += BL;
            end
            beat_push = (owed > 0);
            if (owed > 0) begin
                owed--;
                pushes++;
            end
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while ((busy || sb.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
    endtask

    // Handshake monitor: scoreboard pop plus AR hold-stability rule.
    initial begin
        logic          pv = 1'b0, pr = 1'b0, prst = 1'b0;
        logic [AW-1:0] paddr = '0;
        forever begin
            @(negedge clk);
            if (pv && !pr && prst) begin
                check("ar_hold_valid", 64'(ar_valid), 64'd1);
                check("ar_hold_addr", ar_addr, paddr);
            end
            if (rst_n && ar_valid && ar_ready) begin
                hs_total++;
                if (auto_push) push_starts.push_back(cyc);
                if (sb.size() == 0) begin
                    check("ar_unexpected", 64'(sb.size()), 64'd1);
                end else begin
                    check("ar_addr", ar_addr, sb.pop_front());
                    check("ar_len", 64'(ar_len), 64'(BL - 1));
                end
            end
            pv    = ar_valid;
            pr    = ar_ready;
            paddr = ar_addr;
            prst  = rst_n;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        rst_n       = 1'b0;
        enable      = 1'b0;
        fb_base     = '0;
        frame_beats = '0;
        frame_start = 1'b0;
        fifo_level  = '0;
        beat_push   = 1'b0;
        ar_ready    = 1'b0;

        repeat (3) tick();
        check("rst_valid", 64'(ar_valid), 64'd0);
        check("rst_addr", ar_addr, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_len", 64'(ar_len), 64'd15);
        check("rst_state", 64'(dut.state_q), 64'd0);
        rst_n = 1'b1;

        // Normal frame: four back-to-back bursts, then drain.
        enable    = 1'b1;
        ar_ready  = 1'b1;
        auto_push = 1'b1;
        tick();
        tick();
        fb_base     = 64'h8000_0000;
        frame_beats = 32'd64;
        for (int i = 0; i < 4; i++) sb.push_back(64'h8000_0000 + 64'(i * 128));
        h0     = hs_total;
        pushes = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t1_first_valid", 64'(ar_valid), 64'd1);
        check("t1_first_addr", ar_addr, 64'h8000_0000);
        check("t1_busy", 64'(busy), 64'd1);
        wait_idle(300, "t1");
        check("t1_hs_count", 64'(hs_total - h0), 64'd4);
        check("t1_pushes", 64'(pushes), 64'd64);
        check("t1_outstanding", 64'(dut.out_q), 64'd0);
        check("t1_state_wait", 64'(dut.state_q), 64'd1);
        auto_push = 1'b0;
        beat_push = 1'b0;
        push_starts.delete();
        owed = 0;

        // Credit stall at level 40, released by lowering level to 32.
        fifo_level  = LW'(40);
        fb_base     = 64'h1000;
        frame_beats = 32'd64;
        for (int i = 0; i < 4; i++) sb.push_back(64'h1000 + 64'(i * 128));
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t2_first_valid", 64'(ar_valid), 64'd1);
        check("t2_first_addr", ar_addr, 64'h1000);
        tick();
        check("t2_stall", 64'(ar_valid), 64'd0);
        repeat (3) tick();
        check("t2_stall_hold", 64'(ar_valid), 64'd0);
        check("t2_outstanding", 64'(dut.out_q), 64'd16);
        fifo_level = LW'(32);
        tick();
        check("t2_release", 64'(ar_valid), 64'd1);
        check("t2_release_addr", ar_addr, 64'h1080);
        tick();
        check("t2_stall2", 64'(ar_valid), 64'd0);
        fifo_level = '0;
        for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
        check("t2_sb_left", 64'(sb.size()), 64'd0);
        beat_push = 1'b1;
        repeat (64) tick();
        beat_push = 1'b0;
        tick();
        tick();
        check("t2_busy_end", 64'(busy), 64'd0);
        check("t2_out_end", 64'(dut.out_q), 64'd0);

        // AR backpressure, then simultaneous handshake and push.
        ar_ready    = 1'b0;
        fb_base     = 64'h2000;
        frame_beats = 32'd32;
        sb.push_back(64'h2000);
        sb.push_back(64'h2080);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t3_valid", 64'(ar_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_bp_valid", 64'(ar_valid), 64'd1);
            check("t3_bp_addr", ar_addr, 64'h2000);
        end
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        check("t3_next_valid", 64'(ar_valid), 64'd1);
        check("t3_next_addr", ar_addr, 64'h2080);
        check("t3_out16", 64'(dut.out_q), 64'd16);
        check("t3_sb_one", 64'(sb.size()), 64'd1);
        beat_push = 1'b1;
        repeat (11) tick();
        beat_push = 1'b0;
        check("t3_out5", 64'(dut.out_q), 64'd5);
        ar_ready  = 1'b1;
        beat_push = 1'b1;
        tick();
        ar_ready  = 1'b0;
        beat_push = 1'b0;
        check("t3_out20", 64'(dut.out_q), 64'd20);
        check("t3_valid_off", 64'(ar_valid), 64'd0);
        check("t3_busy_drain", 64'(busy), 64'd1);
        beat_push = 1'b1;
        repeat (20) tick();
        beat_push = 1'b0;
        tick();
        tick();
        check("t3_busy_end", 64'(busy), 64'd0);
        check("t3_sb_left", 64'(sb.size()), 64'd0);

        // Overrun: second pulse mid-frame restarts at the base after drain.
        ar_ready    = 1'b1;
        auto_push   = 1'b1;
        pushes      = 0;
        h0          = hs_total;
        fb_base     = 64'h3000;
        frame_beats = 32'd64;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) sb.push_back(64'h3000 + 64'(i * 128));
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t4_overrun", 64'(overrun), 64'd1);
        check("t4_busy", 64'(busy), 64'd1);
        wait_idle(500, "t4");
        check("t4_hs_count", 64'(hs_total - h0), 64'd8);
        check("t4_pushes", 64'(pushes), 64'd128);
        check("t4_overrun_sticky", 64'(overrun), 64'd1);
        auto_push = 1'b0;
        beat_push = 1'b0;
        push_starts.delete();
        owed   = 0;
        enable = 1'b0;
        repeat (3) tick();
        check("t4_overrun_clr", 64'(overrun), 64'd0);
        check("t4_state_idle", 64'(dut.state_q), 64'd0);

        // Reset while a request is pending.
        enable   = 1'b1;
        ar_ready = 1'b0;
        tick();
        tick();
        fb_base     = 64'h4000;
        frame_beats = 32'd16;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t5_valid", 64'(ar_valid), 64'd1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t5_overrun", 64'(overrun), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_rst_valid", 64'(ar_valid), 64'd0);
        check("t5_rst_addr", ar_addr, 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_overrun", 64'(overrun), 64'd0);
        check("t5_rst_len", 64'(ar_len), 64'd15);
        check("t5_rst_state", 64'(dut.state_q), 64'd0);
        check("t5_rst_out", 64'(dut.out_q), 64'd0);
        tick();
        tick();
        check("t5_no_req", 64'(ar_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
